// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU.
// Latches decoded operands and control, forwards from MEM/WB in EX,
// selects ALU operands, and inserts a single bubble on a load-use hazard.
module id_ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [REGADDR-1:0] id_rs1,
    input  logic [REGADDR-1:0] id_rs2,
    input  logic [REGADDR-1:0] id_rd,
    input  logic [3:0]         id_alu_ctrl,
    input  logic [1:0]         id_asel,
    input  logic               id_bsel,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic [REGADDR-1:0] mem_rd,
    input  logic               mem_reg_write,
    input  logic [XLEN-1:0]    mem_result,
    input  logic [REGADDR-1:0] wb_rd,
    input  logic               wb_reg_write,
    input  logic [XLEN-1:0]    wb_result,
    output logic [XLEN-1:0]    alu_x,
    output logic [XLEN-1:0]    alu_y,
    output logic [3:0]         alu_control,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [XLEN-1:0]    ex_pc,
    output logic [REGADDR-1:0] ex_rd,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               load_use
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [REGADDR-1:0] rs1;
        logic [REGADDR-1:0] rs2;
        logic [REGADDR-1:0] rd;
        logic [3:0]         alu_ctrl;
        logic [1:0]         asel;
        logic               bsel;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

    stage_t             stage_r;
    stage_t             next_s;
    logic [XLEN-1:0]    fwd_rs1_s;
    logic [XLEN-1:0]    fwd_rs2_s;
    logic               load_use_s;

    // Resolve one source operand: x0 is never forwarded, the younger MEM
    // result wins over WB, otherwise the value read in ID is used.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [REGADDR-1:0] rs,
        input logic [XLEN-1:0]    rf_data,
        input logic               mem_we,
        input logic [REGADDR-1:0] mem_dst,
        input logic [XLEN-1:0]    mem_val,
        input logic               wb_we,
        input logic [REGADDR-1:0] wb_dst,
        input logic [XLEN-1:0]    wb_val
    );
        logic [XLEN-1:0] res;
        if (rs == {REGADDR{1'b0}}) begin
            res = {XLEN{1'b0}};
        end else if (mem_we && (mem_dst == rs)) begin
            res = mem_val;
        end else if (wb_we && (wb_dst == rs)) begin
            res = wb_val;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

    // Hazard: the load in EX produces a register the ID instruction reads.
    always_comb begin
        load_use_s = stage_r.valid && stage_r.mem_read &&
                     (stage_r.rd != {REGADDR{1'b0}}) && id_valid &&
                     ((stage_r.rd == id_rs1) || (stage_r.rd == id_rs2));
    end

    // Next stage contents: bubble on flush or load-use, else the ID slot.
    always_comb begin
        next_s = {STAGE_W{1'b0}};
        if (flush || load_use_s) begin
            next_s = {STAGE_W{1'b0}};
        end else begin
            next_s.valid     = id_valid;
            next_s.pc        = id_pc;
            next_s.rs1_data  = id_rs1_data;
            next_s.rs2_data  = id_rs2_data;
            next_s.imm       = id_imm;
            next_s.rs1       = id_rs1;
            next_s.rs2       = id_rs2;
            next_s.rd        = id_rd;
            next_s.alu_ctrl  = id_alu_ctrl;
            next_s.asel      = id_asel;
            next_s.bsel      = id_bsel;
            next_s.reg_write = id_reg_write;
            next_s.mem_read  = id_mem_read;
            next_s.mem_write = id_mem_write;
        end
    end

    // Stage register: flush overrides stall; stall alone holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r <= {STAGE_W{1'b0}};
        end else if (flush || !stall) begin
            stage_r <= next_s;
        end
    end

    // Forwarded operands stay live while stalled.
    always_comb begin
        fwd_rs1_s = fwd_operand(stage_r.rs1, stage_r.rs1_data, mem_reg_write, mem_rd,
                                mem_result, wb_reg_write, wb_rd, wb_result);
        fwd_rs2_s = fwd_operand(stage_r.rs2, stage_r.rs2_data, mem_reg_write, mem_rd,
                                mem_result, wb_reg_write, wb_rd, wb_result);
    end

    // ALU operand selection; store data always takes the forwarded rs2.
    always_comb begin
        case (stage_r.asel)
            2'b01:   alu_x = stage_r.pc;
            2'b10:   alu_x = {XLEN{1'b0}};
            default: alu_x = fwd_rs1_s;
        endcase
        if (stage_r.bsel) begin
            alu_y = stage_r.imm;
        end else begin
            alu_y = fwd_rs2_s;
        end
        ex_store_data = fwd_rs2_s;
    end

    assign alu_control  = stage_r.alu_ctrl;
    assign ex_pc        = stage_r.pc;
    assign ex_rd        = stage_r.rd;
    assign ex_valid     = stage_r.valid;
    assign ex_reg_write = stage_r.reg_write;
    assign ex_mem_read  = stage_r.mem_read;
    assign ex_mem_write = stage_r.mem_write;
    assign load_use     = load_use_s;

endmodule
